instr_sequencer: RTL and testbench

Instruction sequencer for the MPU-6050 I2C path: fetches two-word instructions from the dual-port instruction ROM, decodes them and issues register write/read commands to the I2C command interface, with programmable waits and jumps. It sits directly upstream of the instruction ROM: it drives both ROM address ports and consumes both registered data words. It sits directly upstream of the I2C master: it hands the master one command at a time over a valid/ready handshake and waits for completion.

---
 rtl/instr_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer for the MPU-6050 I2C path: fetches two-word instructions
// from a dual-port ROM and issues write/read/wait/jump/end operations.
module instr_sequencer #(
   parameter int ADDR_ROM_SZ = 4,
   parameter int DATA_ROM_SZ = 16,
   parameter int DLY_SZ      = 16
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   I_START,
   output logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM_A,
   output logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM_B,
   input  logic [DATA_ROM_SZ-1:0] I_DATA_ROM_A,
   input  logic [DATA_ROM_SZ-1:0] I_DATA_ROM_B,
   output logic                   O_CMD_VLD,
   input  logic                   I_CMD_RDY,
   output logic                   O_CMD_RW,
   output logic [7:0]             O_CMD_REG,
   output logic [7:0]             O_CMD_DATA,
   output logic [3:0]             O_CMD_CNT,
   input  logic                   I_CMD_DONE,
   input  logic                   I_CMD_ERR,
   output logic                   O_BUSY,
   output logic                   O_DONE,
   output logic                   O_ERR
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_ISSUE     = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_DELAY     = 3'd5
   } state_t;

   localparam logic [3:0] OP_END   = 4'h0;
   localparam logic [3:0] OP_WRITE = 4'h1;
   localparam logic [3:0] OP_READ  = 4'h2;
   localparam logic [3:0] OP_WAIT  = 4'h3;
   localparam logic [3:0] OP_JUMP  = 4'h4;

   state_t                 state_q, state_d;
   logic [ADDR_ROM_SZ-1:0] pc_q, pc_d;
   logic [ADDR_ROM_SZ-1:0] pc_b_q, pc_b_d;
   logic [DLY_SZ-1:0]      dly_q, dly_d;
   logic                   vld_q, vld_d;
   logic                   rw_q, rw_d;
   logic [7:0]             reg_q, reg_d;
   logic [7:0]             data_q, data_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic [3:0]             op_s;
   logic [3:0]             burst_s;
   logic [7:0]             reg_addr_s;
   logic [DLY_SZ-1:0]      wait_arg_s;
   logic [ADDR_ROM_SZ-1:0] pc_next_s;

   assign op_s       = I_DATA_ROM_A[15:12];
   assign burst_s    = I_DATA_ROM_A[11:8];
   assign reg_addr_s = I_DATA_ROM_A[7:0];
   assign wait_arg_s = DLY_SZ'(I_DATA_ROM_B);
   assign pc_next_s  = pc_q + ADDR_ROM_SZ'(2);

   // Next-state and datapath decode for the sequencer FSM
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      dly_d   = dly_q;
      vld_d   = vld_q;
      rw_d    = rw_q;
      reg_d   = reg_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // a start coinciding with the end-of-program pulse is dropped
            if (I_START && !done_q) begin
               pc_d    = {ADDR_ROM_SZ{1'b0}};
               err_d   = 1'b0;
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (op_s)
               OP_WRITE: begin
                  rw_d    = 1'b0;
                  reg_d   = reg_addr_s;
                  data_d  = I_DATA_ROM_B[7:0];
                  cnt_d   = 4'h0;
                  vld_d   = 1'b1;
                  state_d = S_ISSUE;
               end
               OP_READ: begin
                  rw_d    = 1'b1;
                  reg_d   = reg_addr_s;
                  data_d  = 8'h00;
                  cnt_d   = burst_s;
                  vld_d   = 1'b1;
                  state_d = S_ISSUE;
               end
               OP_WAIT: begin
                  if (wait_arg_s == {DLY_SZ{1'b0}}) begin
                     dly_d = DLY_SZ'(1);
                  end else begin
                     dly_d = wait_arg_s;
                  end
                  state_d = S_DELAY;
               end
               OP_JUMP: begin
                  pc_d    = {I_DATA_ROM_B[ADDR_ROM_SZ-1:1], 1'b0};
                  state_d = S_FETCH;
               end
               OP_END: begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
               default: begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            endcase
         end
         S_ISSUE: begin
            if (I_CMD_RDY) begin
               vld_d   = 1'b0;
               state_d = S_WAIT_DONE;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_WAIT_DONE: begin
            if (I_CMD_DONE) begin
               if (I_CMD_ERR) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  pc_d    = pc_next_s;
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_WAIT_DONE;
            end
         end
         S_DELAY: begin
            if (dly_q == DLY_SZ'(1)) begin
               pc_d    = pc_next_s;
               state_d = S_FETCH;
            end else begin
               dly_d   = dly_q - DLY_SZ'(1);
               state_d = S_DELAY;
            end
         end
         default: begin
            vld_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      pc_b_d = pc_d + ADDR_ROM_SZ'(1);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         pc_q    <= {ADDR_ROM_SZ{1'b0}};
         pc_b_q  <= ADDR_ROM_SZ'(1);
         dly_q   <= {DLY_SZ{1'b0}};
         vld_q   <= 1'b0;
         rw_q    <= 1'b0;
         reg_q   <= 8'h00;
         data_q  <= 8'h00;
         cnt_q   <= 4'h0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pc_b_q  <= pc_b_d;
         dly_q   <= dly_d;
         vld_q   <= vld_d;
         rw_q    <= rw_d;
         reg_q   <= reg_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign O_ADDR_ROM_A = pc_q;
   assign O_ADDR_ROM_B = pc_b_q;
   assign O_CMD_VLD    = vld_q;
   assign O_CMD_RW     = rw_q;
   assign O_CMD_REG    = reg_q;
   assign O_CMD_DATA   = data_q;
   assign O_CMD_CNT    = cnt_q;
   assign O_BUSY       = busy_q;
   assign O_DONE       = done_q;
   assign O_ERR        = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: ROM model, I2C master model and
// directed programs with hand-computed commands, done pulses and timings.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic [3:0]  o_addr_rom_a, o_addr_rom_b;
   logic [15:0] rom_a = 16'h0000, rom_b = 16'h0000;
   logic        o_cmd_vld, o_cmd_rw;
   logic        i_cmd_rdy = 1'b0;
   logic [7:0]  o_cmd_reg, o_cmd_data;
   logic [3:0]  o_cmd_cnt;
   logic        i_cmd_done = 1'b0, i_cmd_err = 1'b0;
   logic        o_busy, o_done, o_err;

   logic [15:0] rom [0:15];
   int          checks = 0;
   int          errors = 0;
   int          rdy_lat = 0;
   int          done_lat = 5;
   logic        err_resp = 1'b0;
   logic [20:0] exp_cmd_q[$];
   logic        exp_done_q[$];
   logic [20:0] exp_cmd;
   logic        exp_err;

   instr_sequencer #(.ADDR_ROM_SZ(4), .DATA_ROM_SZ(16), .DLY_SZ(16)) dut (
      .CLK(clk), .RST(rst), .I_START(i_start),
      .O_ADDR_ROM_A(o_addr_rom_a), .O_ADDR_ROM_B(o_addr_rom_b),
      .I_DATA_ROM_A(rom_a), .I_DATA_ROM_B(rom_b),
      .O_CMD_VLD(o_cmd_vld), .I_CMD_RDY(i_cmd_rdy), .O_CMD_RW(o_cmd_rw),
      .O_CMD_REG(o_cmd_reg), .O_CMD_DATA(o_cmd_data), .O_CMD_CNT(o_cmd_cnt),
      .I_CMD_DONE(i_cmd_done), .I_CMD_ERR(i_cmd_err),
      .O_BUSY(o_busy), .O_DONE(o_done), .O_ERR(o_err)
   );

   always #5 clk = ~clk;

   // Registered dual-port ROM, one cycle latency
   always @(posedge clk) begin
      rom_a <= rom[o_addr_rom_a];
      rom_b <= rom[o_addr_rom_b];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // I2C master model: rdy after rdy_lat cycles of valid, done done_lat cycles after accept
   initial begin : master
      int wait_cnt;
      int pend;
      wait_cnt = 0;
      pend = 0;
      forever begin
         @(negedge clk);
         i_cmd_done = 1'b0;
         i_cmd_err  = 1'b0;
         if (rst) begin
            i_cmd_rdy = 1'b0;
            wait_cnt = 0;
            pend = 0;
         end else if (i_cmd_rdy) begin
            i_cmd_rdy = 1'b0;
            pend = done_lat;
            wait_cnt = 0;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               i_cmd_done = 1'b1;
               i_cmd_err  = err_resp;
            end
         end else if (o_cmd_vld) begin
            if (wait_cnt >= rdy_lat) i_cmd_rdy = 1'b1;
            else wait_cnt++;
         end
      end
   end

   // Scoreboard monitor: compares accepted commands and done pulses against queues
   always @(posedge clk) begin
      if (!rst && o_cmd_vld && i_cmd_rdy) begin
         if (exp_cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_unexpected: got rw=%0d reg=0x%0h data=0x%0h cnt=%0d expected none",
                     o_cmd_rw, o_cmd_reg, o_cmd_data, o_cmd_cnt);
         end else begin
            exp_cmd = exp_cmd_q.pop_front();
            chk("cmd_fields", {11'd0, o_cmd_rw, o_cmd_reg, o_cmd_data, o_cmd_cnt}, {11'd0, exp_cmd});
         end
      end
      if (!rst && o_done) begin
         if (exp_done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected: got done=1 expected none");
         end else begin
            exp_err = exp_done_q.pop_front();
            chk("done_err", {31'd0, o_err}, {31'd0, exp_err});
            chk("done_busy", {31'd0, o_busy}, 32'd0);
         end
      end
   end

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
   endtask

   task automatic pulse_start();
      @(negedge clk) i_start = 1'b1;
      @(negedge clk) i_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (o_done) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
      end
   endtask

   task automatic count_busy(input int budget, input bit poke, output int n);
      n = 0;
      for (int i = 0; i < budget; i++) begin
         if (!o_busy) break;
         n++;
         if (poke && n == 5) i_start = 1'b1;
         if (poke && n == 6) i_start = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin : stim
      int n;
      int hi;
      bit held_ok;
      bit seen;
      clear_rom();

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_vld", {31'd0, o_cmd_vld}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_done", {31'd0, o_done}, 32'd0);
      chk("rst_err", {31'd0, o_err}, 32'd0);
      chk("rst_addr_a", {28'd0, o_addr_rom_a}, 32'd0);
      chk("rst_addr_b", {28'd0, o_addr_rom_b}, 32'd1);
      chk("rst_fields", {11'd0, o_cmd_rw, o_cmd_reg, o_cmd_data, o_cmd_cnt}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // WRITE then END, valid two cycles after start
      rom[0] = 16'h106B; rom[1] = 16'h0000;
      rdy_lat = 0;
      exp_cmd_q.push_back({1'b0, 8'h6B, 8'h00, 4'h0});
      exp_done_q.push_back(1'b0);
      pulse_start();
      chk("t1_vld_fetch", {31'd0, o_cmd_vld}, 32'd0);
      chk("t1_busy", {31'd0, o_busy}, 32'd1);
      @(negedge clk);
      chk("t1_vld_decode", {31'd0, o_cmd_vld}, 32'd0);
      @(negedge clk);
      chk("t1_vld_issue", {31'd0, o_cmd_vld}, 32'd1);
      @(negedge clk);
      chk("t1_vld_one_cycle", {31'd0, o_cmd_vld}, 32'd0);
      wait_done(50, "t1");
      chk("t1_err", {31'd0, o_err}, 32'd0);
      repeat (2) @(negedge clk);

      // READ burst held under backpressure
      clear_rom();
      rom[0] = 16'h253B;
      rdy_lat = 4;
      exp_cmd_q.push_back({1'b1, 8'h3B, 8'h00, 4'h5});
      exp_done_q.push_back(1'b0);
      pulse_start();
      hi = 0;
      held_ok = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (o_cmd_vld) begin
            hi++;
            if ({o_cmd_rw, o_cmd_reg, o_cmd_cnt} != {1'b1, 8'h3B, 4'h5}) held_ok = 1'b0;
         end else if (hi > 0) begin
            break;
         end
      end
      chk("t2_vld_cycles", hi, 32'd5);
      chk("t2_fields_held", {31'd0, held_ok}, 32'd1);
      wait_done(50, "t2");
      rdy_lat = 0;
      repeat (2) @(negedge clk);

      // WAIT 10 then END: busy for 14 cycles
      clear_rom();
      rom[0] = 16'h3000; rom[1] = 16'h000A;
      exp_done_q.push_back(1'b0);
      pulse_start();
      count_busy(60, 1'b0, n);
      chk("t3_busy_len", n, 32'd14);
      chk("t3_done_at_idle", {31'd0, o_done}, 32'd1);
      repeat (2) @(negedge clk);

      // JUMP 0x000F lands on 14, WRITE there, wrap to 0 which then holds END
      clear_rom();
      rom[0] = 16'h4000; rom[1] = 16'h000F;
      rom[14] = 16'h1A55; rom[15] = 16'h00C3;
      exp_cmd_q.push_back({1'b0, 8'h55, 8'hC3, 4'h0});
      exp_done_q.push_back(1'b0);
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (o_cmd_vld) seen = 1'b1;
      end
      chk("t4_vld_seen", {31'd0, seen}, 32'd1);
      chk("t4_addr_a_at_14", {28'd0, o_addr_rom_a}, 32'd14);
      chk("t4_addr_b_at_15", {28'd0, o_addr_rom_b}, 32'd15);
      @(negedge clk);
      rom[0] = 16'h0000; rom[1] = 16'h0000;
      for (int i = 0; i < 30; i++) begin
         if (o_addr_rom_a != 4'd14) break;
         @(negedge clk);
      end
      chk("t4_wrap_a", {28'd0, o_addr_rom_a}, 32'd0);
      chk("t4_wrap_b", {28'd0, o_addr_rom_b}, 32'd1);
      wait_done(50, "t4");
      repeat (2) @(negedge clk);

      // NACK on the command: error, done, idle; start coincident with done ignored
      clear_rom();
      rom[0] = 16'h106B; rom[1] = 16'h0080;
      err_resp = 1'b1;
      exp_cmd_q.push_back({1'b0, 8'h6B, 8'h80, 4'h0});
      exp_done_q.push_back(1'b1);
      pulse_start();
      wait_done(50, "t5");
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      err_resp = 1'b0;
      chk("t5_start_on_done_busy", {31'd0, o_busy}, 32'd0);
      chk("t5_err_sticky", {31'd0, o_err}, 32'd1);
      repeat (2) @(negedge clk);

      // Illegal opcode 0x7; the accepted start clears the old error first
      clear_rom();
      rom[0] = 16'h7000;
      exp_done_q.push_back(1'b1);
      pulse_start();
      chk("t6_err_cleared", {31'd0, o_err}, 32'd0);
      wait_done(20, "t6");
      chk("t6_err_set", {31'd0, o_err}, 32'd1);
      repeat (2) @(negedge clk);

      // Plain END clears the error
      clear_rom();
      exp_done_q.push_back(1'b0);
      pulse_start();
      chk("t7_err_cleared", {31'd0, o_err}, 32'd0);
      wait_done(20, "t7");
      repeat (2) @(negedge clk);

      // START pulsed while busy in WAIT 20 is ignored: busy stays 24 cycles
      clear_rom();
      rom[0] = 16'h3000; rom[1] = 16'h0014;
      exp_done_q.push_back(1'b0);
      pulse_start();
      count_busy(80, 1'b1, n);
      i_start = 1'b0;
      chk("t8_busy_len", n, 32'd24);
      repeat (4) @(negedge clk);
      chk("t8_no_restart", {31'd0, o_busy}, 32'd0);

      // RST while a command waits in ISSUE
      clear_rom();
      rom[0] = 16'h253B;
      rdy_lat = 100;
      pulse_start();
      repeat (2) @(negedge clk);
      chk("t9_vld_before_rst", {31'd0, o_cmd_vld}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t9_vld", {31'd0, o_cmd_vld}, 32'd0);
      chk("t9_busy", {31'd0, o_busy}, 32'd0);
      chk("t9_done", {31'd0, o_done}, 32'd0);
      chk("t9_addr", {24'd0, o_addr_rom_a, o_addr_rom_b}, 32'h01);
      chk("t9_fields", {11'd0, o_cmd_rw, o_cmd_reg, o_cmd_data, o_cmd_cnt}, 32'd0);
      rst = 1'b0;
      rdy_lat = 0;
      repeat (10) @(negedge clk);
      chk("t9_idle", {31'd0, o_busy}, 32'd0);

      chk("cmd_queue_empty", exp_cmd_q.size(), 32'd0);
      chk("done_queue_empty", exp_done_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000 ns");
      $fatal(1);
   end

endmodule
